// File: rtl/hermes_packet_injector_pkg.sv
// Shared types for the Hermes packet injector: FSM state encoding and bus constants.
package hermes_packet_injector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEG1,
    SEG2,
    DRAIN,
    DONE
  } injector_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/hermes_packet_injector_if.sv
// Memory read port and Hermes local-port signals of the packet injector.
interface hermes_packet_injector_if #(
  parameter int unsigned HERMES_FLIT_SIZE = 32
);
  logic                        mem_en;
  logic [31:0]                 mem_addr;
  logic [31:0]                 mem_data;
  logic                        noc_tx;
  logic                        noc_eop;
  logic                        noc_credit;
  logic [HERMES_FLIT_SIZE-1:0] noc_data;

  modport master (
    output mem_en, mem_addr, noc_tx, noc_eop, noc_data,
    input  mem_data, noc_credit
  );

  modport slave (
    input  mem_en, mem_addr, noc_tx, noc_eop, noc_data,
    output mem_data, noc_credit
  );
endinterface

// File: rtl/hermes_packet_injector_ringbuffer.sv
// Circular FIFO with valid/ack handshakes on both sides; depth must be a power of two.
module RingBuffer #(
  parameter int unsigned DATA_SIZE   = 33,
  parameter int unsigned BUFFER_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 rx_ack_o,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 tx_ack_i,
  output logic [DATA_SIZE-1:0] data_o
);
  localparam int unsigned PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);

  logic [DATA_SIZE-1:0] buf_q [BUFFER_SIZE];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  assign tx_o     = (count_q != '0);
  assign rx_ack_o = (count_q != CW'(BUFFER_SIZE));
  assign push     = rx_i && rx_ack_o;
  assign pop      = tx_ack_i && tx_o;
  assign data_o   = buf_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < BUFFER_SIZE; i++) buf_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) buf_q[tail_q] <= data_i;
    end
  end

endmodule

// File: rtl/hermes_packet_injector.sv
// Reads a header segment then a payload segment from memory and streams them as
// Hermes flits under credit flow control, tagging the final flit with EOP.
module hermes_packet_injector
  import hermes_packet_injector_pkg::*;
#(
  parameter int unsigned HERMES_FLIT_SIZE = 32,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [31:0]              size_i,
  input  logic [31:0]              address_i,
  input  logic [31:0]              size_2_i,
  input  logic [31:0]              address_2_i,
  output logic                     busy_o,
  output logic                     done_o,
  hermes_packet_injector_if.master bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  injector_state_t state_q, state_d;
  logic [31:0]     addr1_q, addr1_d, rem1_q, rem1_d;
  logic [31:0]     addr2_q, addr2_d, rem2_q, rem2_d;
  logic            inflight_q, inflight_d;
  logic            inflight_eop_q, inflight_eop_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;

  logic                      issue, last_read, credit_space;
  logic                      push, pop, fifo_tx, fifo_rx_ack;
  logic [31:0]               rd_addr;
  logic [HERMES_FLIT_SIZE:0] fifo_wdata, fifo_rdata;

  // Occupancy plus the one possible in-flight read bounds what can land in the FIFO.
  assign credit_space = (32'(fifo_count_q) + 32'(inflight_q)) < FIFO_DEPTH;

  always_comb begin
    state_d        = state_q;
    addr1_d        = addr1_q;
    rem1_d         = rem1_q;
    addr2_d        = addr2_q;
    rem2_d         = rem2_q;
    issue          = 1'b0;
    last_read      = 1'b0;
    rd_addr        = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr1_d = address_i;
          rem1_d  = size_i;
          addr2_d = address_2_i;
          rem2_d  = size_2_i;
          // An empty packet passes through DRAIN so done lands two cycles after start.
          if (size_i != '0)        state_d = SEG1;
          else if (size_2_i != '0) state_d = SEG2;
          else                     state_d = DRAIN;
        end
      end
      SEG1: begin
        if (credit_space) begin
          issue     = 1'b1;
          rd_addr   = addr1_q;
          addr1_d   = addr1_q + WORD_BYTES;
          rem1_d    = rem1_q - 32'd1;
          last_read = (rem1_q == 32'd1) && (rem2_q == '0);
          if (rem1_q == 32'd1) state_d = (rem2_q != '0) ? SEG2 : DRAIN;
        end
      end
      SEG2: begin
        if (credit_space) begin
          issue     = 1'b1;
          rd_addr   = addr2_q;
          addr2_d   = addr2_q + WORD_BYTES;
          rem2_d    = rem2_q - 32'd1;
          last_read = (rem2_q == 32'd1);
          if (rem2_q == 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!fifo_tx && !inflight_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d     = issue;
    inflight_eop_d = last_read;
    fifo_count_d   = fifo_count_q;
    if (push && !pop)      fifo_count_d = fifo_count_q + CW'(1);
    else if (!push && pop) fifo_count_d = fifo_count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      addr1_q        <= '0;
      rem1_q         <= '0;
      addr2_q        <= '0;
      rem2_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_eop_q <= 1'b0;
      fifo_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      addr1_q        <= addr1_d;
      rem1_q         <= rem1_d;
      addr2_q        <= addr2_d;
      rem2_q         <= rem2_d;
      inflight_q     <= inflight_d;
      inflight_eop_q <= inflight_eop_d;
      fifo_count_q   <= fifo_count_d;
    end
  end

  assign push       = inflight_q;
  assign pop        = fifo_tx && bus.noc_credit;
  assign fifo_wdata = {inflight_eop_q, bus.mem_data[HERMES_FLIT_SIZE-1:0]};

  RingBuffer #(
    .DATA_SIZE  (HERMES_FLIT_SIZE + 1),
    .BUFFER_SIZE(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rx_i    (push),
    .rx_ack_o(fifo_rx_ack),
    .data_i  (fifo_wdata),
    .tx_o    (fifo_tx),
    .tx_ack_i(bus.noc_credit),
    .data_o  (fifo_rdata)
  );

  assign bus.mem_en   = issue;
  assign bus.mem_addr = rd_addr;
  assign bus.noc_tx   = fifo_tx;
  assign bus.noc_eop  = fifo_rdata[HERMES_FLIT_SIZE];
  assign bus.noc_data = fifo_rdata[HERMES_FLIT_SIZE-1:0];
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> fifo_rx_ack);
  a_data_known:  assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !$isunknown(bus.mem_data));

endmodule

// File: tb/tb_hermes_packet_injector.sv
// Scoreboard bench: expected reads/flits/done timing come from a segment-level model.
module tb_hermes_packet_injector;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, done;
  logic [31:0] size, addr, size2, addr2;
  logic        start16, busy16, done16;
  logic [31:0] size16, addr16, size2_16, addr2_16;

  hermes_packet_injector_if #(.HERMES_FLIT_SIZE(32)) bus ();
  hermes_packet_injector_if #(.HERMES_FLIT_SIZE(16)) bus16 ();

  hermes_packet_injector #(.HERMES_FLIT_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .size_i(size), .address_i(addr),
    .size_2_i(size2), .address_2_i(addr2), .busy_o(busy), .done_o(done), .bus(bus.master)
  );

  hermes_packet_injector #(.HERMES_FLIT_SIZE(16), .FIFO_DEPTH(DEPTH)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .size_i(size16), .address_i(addr16),
    .size_2_i(size2_16), .address_2_i(addr2_16), .busy_o(busy16), .done_o(done16), .bus(bus16.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_mode = 0;
  int credit_mode = 0;
  int exp_done_cyc = -1;
  int done_cnt = 0;
  int first_tx_cyc = -1;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  logic        hold_valid = 1'b0;
  logic [32:0] hold_val = '0;
  logic [31:0] exp_reads [$];
  logic [32:0] exp_flits [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: data for a read appears in the following cycle; otherwise a poison word.
  initial begin
    logic        pend_en;
    logic [31:0] pend_addr;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      pend_en   = bus.mem_en;
      pend_addr = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_data = pend_en ? mem_word(pend_addr) : 32'h0BAD_0BAD;
    end
  end

  assign bus16.mem_data = 32'hDEAD_BEEF;

  initial begin
    bus.noc_credit = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (credit_mode)
        0:       bus.noc_credit = 1'b1;
        1:       bus.noc_credit = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       bus.noc_credit = 1'($urandom_range(0, 1));
        default: bus.noc_credit = 1'b0;
      endcase
    end
  end

  // Monitor: compares every read, every transferred flit and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) begin
        issued++;
        if (issued - popped > max_out) max_out = issued - popped;
        if (exp_reads.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_read: got addr %0h expected no read", bus.mem_addr);
        end else begin
          check("read_addr", 64'(bus.mem_addr), 64'(exp_reads.pop_front()));
        end
      end
      if (hold_valid && bus.noc_tx) check("hold_stable", 64'({bus.noc_eop, bus.noc_data}), 64'(hold_val));
      hold_valid = bus.noc_tx && !bus.noc_credit;
      hold_val   = {bus.noc_eop, bus.noc_data};
      if (bus.noc_tx && first_tx_cyc < 0) first_tx_cyc = cyc;
      if (bus.noc_tx && bus.noc_credit) begin
        popped++;
        if (exp_flits.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_flit: got %0h expected no flit", {bus.noc_eop, bus.noc_data});
        end else begin
          logic [32:0] e;
          e = exp_flits.pop_front();
          check("flit", 64'({bus.noc_eop, bus.noc_data}), 64'(e));
          if (e[32]) exp_done_cyc = cyc + 2;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done_cyc < 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          check("done_time", 64'(cyc), 64'(exp_done_cyc));
        end
        exp_done_cyc = -1;
      end
    end
  end

  task automatic start_pkt(input logic [31:0] s1, a1, s2, a2, output int sc);
    for (int unsigned i = 0; i < s1; i++) begin
      logic [31:0] ad;
      ad = a1 + 32'(4 * i);
      exp_reads.push_back(ad);
      exp_flits.push_back({(s2 == 0) && (i == s1 - 1), mem_word(ad)});
    end
    for (int unsigned i = 0; i < s2; i++) begin
      logic [31:0] ad;
      ad = a2 + 32'(4 * i);
      exp_reads.push_back(ad);
      exp_flits.push_back({i == s2 - 1, mem_word(ad)});
    end
    size = s1; addr = a1; size2 = s2; addr2 = a2;
    start = 1'b1;
    sc = cyc;
    if (s1 == 0 && s2 == 0) exp_done_cyc = cyc + 2;
    tick();
    start = 1'b0;
    size = $urandom(); addr = $urandom(); size2 = $urandom(); addr2 = $urandom();
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic run_pkt(input logic [31:0] s1, a1, s2, a2, output int sc);
    int n0;
    n0 = done_cnt;
    start_pkt(s1, a1, s2, a2, sc);
    for (int k = 0; k < 300 && done_cnt == n0; k++) tick();
    if (done_cnt == n0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected one within 300 cycles");
    end
    tick();
    check("busy_idle", 64'(busy), 64'(0));
    check("flits_left", 64'(exp_flits.size()), 64'(0));
    check("reads_left", 64'(exp_reads.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int sc, iss0, n0, nfl, d16;
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0;
    size = '0; addr = '0; size2 = '0; addr2 = '0;
    size16 = '0; addr16 = '0; size2_16 = '0; addr2_16 = '0;
    bus16.noc_credit = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", 64'({bus.noc_tx, bus.noc_eop, bus.mem_en, busy, done}), 64'(0));
    check("reset_data", 64'(bus.noc_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // Header and payload, constant credit.
    mem_mode = 0; credit_mode = 0; first_tx_cyc = -1;
    run_pkt(32'd2, 32'h100, 32'd3, 32'h200, sc);
    check("first_flit_latency", 64'(first_tx_cyc), 64'(sc + 3));

    // Same packet under 1-0-0-1 credit pattern.
    credit_mode = 1; max_out = 0;
    run_pkt(32'd2, 32'h100, 32'd3, 32'h200, sc);
    check("max_outstanding_le_depth", 64'(max_out <= DEPTH), 64'(1));

    // Segment 2 empty, then both empty.
    credit_mode = 0;
    run_pkt(32'd1, 32'h40, 32'd0, 32'h80, sc);
    run_pkt(32'd0, 32'h10, 32'd0, 32'h20, sc);
    // Segment 1 empty only.
    run_pkt(32'd0, 32'h10, 32'd2, 32'h500, sc);

    // Randomized packets, random credit, including address wrap.
    mem_mode = 1; credit_mode = 2;
    run_pkt(32'd4, 32'hFFFF_FFF8, 32'd2, 32'h0000_1000, sc);
    for (int n = 0; n < 12; n++) begin
      run_pkt(32'($urandom_range(0, 6)), $urandom() & 32'hFFFF_FFFC,
              32'($urandom_range(0, 6)), $urandom() & 32'hFFFF_FFFC, sc);
    end

    // Long packet stalled by credit, ignored start, then reset mid-packet.
    credit_mode = 3;
    iss0 = issued;
    start_pkt(32'd16, 32'h2000, 32'd0, 32'h0, sc);
    repeat (10) tick();
    check("stall_reads_eq_depth", 64'(issued - iss0), 64'(DEPTH));
    size = 32'd1; addr = 32'h900; size2 = '0; addr2 = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_after_ignored_start", 64'(busy), 64'(1));
    credit_mode = 0;
    repeat (4) tick();
    credit_mode = 3;
    tick();
    rst_n = 1'b0;
    exp_reads.delete(); exp_flits.delete();
    exp_done_cyc = -1; hold_valid = 1'b0;
    #1;
    check("abort_ctrl", 64'({bus.noc_tx, bus.noc_eop, bus.mem_en, busy, done}), 64'(0));
    check("abort_data", 64'(bus.noc_data), 64'(0));
    check("abort_addr", 64'(bus.mem_addr), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    n0 = done_cnt;
    repeat (6) tick();
    check("no_done_after_reset", 64'(done_cnt - n0), 64'(0));
    check("fifo_empty_after_reset", 64'(bus.noc_tx), 64'(0));
    credit_mode = 0; mem_mode = 0;
    run_pkt(32'd1, 32'h300, 32'd0, 32'h0, sc);

    // 16-bit flit instance truncates memory words to their low half.
    size16 = 32'd2; addr16 = 32'h10; size2_16 = '0; addr2_16 = '0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    nfl = 0; d16 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus16.noc_tx && bus16.noc_credit) begin
        check("trunc_data", 64'(bus16.noc_data), 64'(16'hBEEF));
        check("trunc_eop", 64'(bus16.noc_eop), 64'(nfl == 1));
        nfl++;
      end
      if (done16) d16++;
    end
    check("trunc_count", 64'(nfl), 64'(2));
    check("trunc_done", 64'(d16), 64'(1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
